// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit and receive cores.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserializer with a 2-flop input synchronizer and mid-bit sampling.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta;
  logic                 rx_sync;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame receiver; after the start-bit half period every sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 serializer: start bit, eight data bits LSB first, one stop bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  // Frame sequencer; tx is driven straight from a register so the pin never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shreg   <= tx_data;
            cnt     <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx   <= idx + IW'(1);
              shreg <= {1'b0, shreg[DATA_BITS-1:1]};
              tx    <= shreg[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_working.sv
// Full-duplex 8N1 UART: independent transmit and receive cores on one clock.
module uart_working #(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

endmodule

// File: tb/tb_uart_working.sv
// Self-checking bench for uart_working in loopback and with a hand-driven rx line.
module tb_uart_working;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;

  assign rx = loop_en ? tx : rx_drv;

  uart_working #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  int last_cyc = 0;
  int width_err = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receive monitor: log every rx_valid pulse and flag any wider than one cycle.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vcount    = vcount + 1;
      last_data = rx_data;
      last_cyc  = cyc;
      if (prev_valid) width_err = width_err + 1;
    end
    prev_valid = (rx_valid === 1'b1);
  end

  typedef struct {
    logic [7:0] data;
    logic [0:9] wave;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference frame: line level for each of the ten bit slots, first slot first.
  function automatic logic [0:9] model_wave(input logic [7:0] b);
    logic [9:0] f;
    logic [0:9] w;
    f = {1'b1, b, 1'b0};
    for (int t = 0; t < 10; t++) w[t] = f[t];
    return w;
  endfunction

  // Starts a frame at the current negedge and checks it bit by bit; returns at
  // the first negedge where the transmitter is idle again.
  task automatic send_frame(input logic [7:0] b, input logic [0:9] wave, input int poke_at);
    int bad_tx, bad_busy, first_bad, v0, k;
    v0 = vcount; bad_tx = 0; bad_busy = 0; first_bad = -1; k = 0;
    tx_data = b;
    tx_start = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) begin
        tx_start = 1'b0;
        k = cyc;
      end
      if (i == poke_at) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
      end else if (poke_at >= 0 && i == poke_at + 1) begin
        tx_start = 1'b0;
        tx_data  = b;
      end
      if (tx !== wave[i / CPB]) begin
        bad_tx++;
        if (first_bad < 0) first_bad = i;
      end
      if (tx_busy !== 1'b1) bad_busy++;
    end
    @(negedge clk);
    if (bad_tx != 0) $display("  first tx deviation at cycle %0d of frame 0x%02h", first_bad, b);
    chk("tx_wave_bad_cycles", bad_tx, 0);
    chk("tx_busy_low_cycles", bad_busy, 0);
    chk("tx_busy_fall", int'(tx_busy), 0);
    chk("tx_idle_level", int'(tx), 1);
    chk("rx_pulse_count", vcount - v0, 1);
    chk("rx_data", int'(last_data), int'(b));
    chk_range("rx_latency", last_cyc - k, 9 * CPB + CPB / 2 + 2, 9 * CPB + CPB / 2 + 4);
  endtask

  // Hand-drives one frame onto rx with a chosen stop-bit level.
  task automatic ser_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int t = 0; t < 10; t++) begin
      rx_drv = f[t];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int v0, low_cnt;
    logic [7:0] rb;

    vecs[0] = '{8'hAA, 10'b0010101011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h01, 10'b0100000001};
    vecs[4] = '{8'h80, 10'b0000000011};

    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_tx_busy", int'(tx_busy), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);

    // Back-to-back table frames, each start issued the cycle tx_busy falls
    for (int i = 0; i < 5; i++) send_frame(vecs[i].data, vecs[i].wave, -1);

    // Start request while busy must be ignored
    send_frame(8'hAA, vecs[0].wave, 450);
    v0 = vcount; low_cnt = 0;
    repeat (11 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
    end
    chk("ignored_start_tx_activity", low_cnt, 0);
    chk("ignored_start_no_frame", vcount - v0, 0);
    chk("ignored_start_rx_data", int'(rx_data), 8'hAA);

    // Glitch on rx, then a framing error, then a good frame
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    v0 = vcount;
    rx_drv = 1'b0;
    repeat (30) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_valid", vcount - v0, 0);
    ser_send(8'h77, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("framing_error_no_valid", vcount - v0, 0);
    chk("framing_error_rx_data_held", int'(rx_data), 8'hAA);
    ser_send(8'h3C, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("after_error_count", vcount - v0, 1);
    chk("after_error_data", int'(last_data), 8'h3C);
    loop_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of data bit 4
    v0 = vcount;
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("pre_reset_busy", int'(tx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_tx", int'(tx), 1);
    chk("mid_reset_busy", int'(tx_busy), 0);
    rst = 1'b0;
    repeat (11 * CPB) @(negedge clk);
    chk("mid_reset_no_valid", vcount - v0, 0);
    chk("mid_reset_rx_data", int'(rx_data), 0);
    send_frame(8'hA5, 10'b0101001011, -1);

    // Random frames against the reference model, with random idle gaps
    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(rb, model_wave(rb), -1);
    end

    chk("rx_valid_width_violations", width_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_working.md
# uart_working

Full-duplex 8N1 UART containing one transmitter and one receiver. Both share a clock and a bit period of `CLKS_PER_BIT` clocks. It sits between a byte-wide parallel host interface and the serial pins. Loopback (`tx` wired to `rx`) is the primary verification configuration.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 100: clocks per serial bit. Must be ≥ 4. The counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  in  1: the single clock. The whole design is on it.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_data`  in  8: byte to send. Sampled only on a cycle where `tx_start` is accepted.
- `tx_start`  in  1: send request. Accepted only when the TX is idle.
- `tx`  out  1: serial output. Idle level is 1.
- `tx_busy`  out  1: high while a frame is in progress.
- `rx`  in  1: serial input. Asynchronous to `clk`.
- `rx_data`  out  8: last byte received correctly. Holds until the next good frame.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` is updated.

## Operation

Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). No parity.

TX state machine (IDLE → START → DATA → STOP → IDLE):
- IDLE
  - `tx`=1, `tx_busy`=0.
  - When `tx_start`=1 at a clock edge: latch `tx_data`, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` clocks.
- DATA: drive bit i for `CLKS_PER_BIT` clocks each, i = 0..7. A 3-bit index counts the bits.
- STOP: `tx`=1 for `CLKS_PER_BIT` clocks, then go to IDLE.
- `tx_busy`=1 in START, DATA and STOP.
- `tx_start` is ignored while busy. It is not queued.

RX state machine (IDLE → START → DATA → STOP → IDLE, plus a WAIT_IDLE error state):
- Synchronizer: `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- IDLE: on a synchronized 0, go to START.
- START
  - Count `CLKS_PER_BIT/2` clocks, then re-sample.
  - Still 0: go to DATA with the counter reset.
  - 1 (glitch): go back to IDLE.
- DATA: sample every `CLKS_PER_BIT` clocks, which is mid-bit. Shift the bits in LSB first. After 8 bits go to STOP.
- STOP
  - Wait `CLKS_PER_BIT` clocks, then sample.
  - Sample = 1: load `rx_data` from the shift register, pulse `rx_valid` for one cycle, go to IDLE.
  - Sample = 0 (framing error): discard the byte, no `rx_valid`, go to WAIT_IDLE.
- WAIT_IDLE: stay until the line is 1, then go to IDLE.

Reset:
- TX: `tx`=1, `tx_busy`=0, state IDLE.
- RX: `rx_data`=8'h00, `rx_valid`=0, state IDLE, synchronizer flops = 1.
- A reset asserted mid-frame aborts the frame immediately on that edge. No partial byte is delivered.

Both directions run independently. Simultaneous TX and RX activity is legal.

## Timing

- `tx_start` sampled high at edge k:
  - `tx`=0 and `tx_busy`=1 are visible after edge k.
  - Each bit lasts exactly `CLKS_PER_BIT` clocks.
  - Full frame = 10×`CLKS_PER_BIT` clocks.
  - `tx_busy` falls after edge k+10×`CLKS_PER_BIT`. That is the first cycle a new start is accepted.
- RX in loopback: `rx_valid` asserts 9.5×`CLKS_PER_BIT` + 3 ±1 clocks after `tx` falls. The 3 covers 2 synchronizer stages plus the registered output.
- `rx_valid` is exactly 1 cycle wide. `rx_data` is stable from that cycle on.
- Back-to-back frames: the RX re-arms in IDLE during the stop bit, so it catches a start bit that immediately follows the stop bit.

## Structure

- Shared package `uart_pkg`:
  - `uart_state_e` enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants: `DATA_BITS=8`, `STOP_BITS=1`.
- Two sub-modules, `uart_tx_core` and `uart_rx_core`, each with its own bit counter and state register. `uart_working` only instantiates and wires them.

## Test plan

All scenarios use `CLKS_PER_BIT`=100 and loopback (`tx`→`rx`).
- Reset: hold `rst`=1 for 5 cycles → `tx`=1, `tx_busy`=0, `rx_valid`=0, `rx_data`=8'h00.
- Send 0xAA → `tx` pattern 0,0,1,0,1,0,1,0,1,1 at 100 clocks per bit. `tx_busy` high for 1000 clocks. `rx_data`=8'hAA with one `rx_valid` pulse about 953 clocks after start.
- Send 0x00 then 0xFF back-to-back, with the second start issued the cycle `tx_busy` falls → two `rx_valid` pulses, data 8'h00 then 8'hFF.
- Pulse `tx_start` again while busy, with `tx_data`=0x55 → ignored: still only one frame, `rx_data` stays 8'hAA.
- Drive `rx` low for 30 clocks (glitch) → RX returns to IDLE, no `rx_valid`. Drive a frame with stop bit = 0 → no `rx_valid`; next good frame 0x3C is received correctly.
- Assert `rst` at bit 4 of a frame → `tx`=1 and `tx_busy`=0 the next cycle, no `rx_valid`. A fresh 0xA5 afterwards is received correctly.
